// File: rtl/l_next_logger_if.sv
// Downstream cache bus and drain-side handshake/statistics bundle for l_next_logger.
interface l_next_logger_if #(
  parameter int ADDR_W = 26,
  parameter int CNT_W  = 16
);
  logic [1:0]        cmd_in;
  logic [ADDR_W-1:0] add_in;
  logic              done;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_cmd;
  logic [ADDR_W-1:0] out_add;
  logic [CNT_W-1:0]  cnt_read;
  logic [CNT_W-1:0]  cnt_write;
  logic [CNT_W-1:0]  cnt_rwim;
  logic [CNT_W-1:0]  cnt_drop;
  logic              full;
  logic              empty;

  modport master (
    output cmd_in, add_in, done, out_ready,
    input  out_valid, out_cmd, out_add,
    input  cnt_read, cnt_write, cnt_rwim, cnt_drop, full, empty
  );

  modport slave (
    input  cmd_in, add_in, done, out_ready,
    output out_valid, out_cmd, out_add,
    output cnt_read, cnt_write, cnt_rwim, cnt_drop, full, empty
  );
endinterface

// File: rtl/l_next_logger.sv
// Captures non-idle cache bus commands into a FWFT FIFO and keeps saturating per-command stats.
// Latency: command captured at edge k is at the head / counted in cycle k+1; pop visible next cycle.
// Backpressure: none upstream; commands arriving while full (and not popping) are dropped and counted.
module l_next_logger #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 26,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic reset,
  l_next_logger_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_RWIM  = 2'd3
  } cmd_e;

  typedef struct packed {
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] add;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;
  logic [CNT_W-1:0]  cnt_read_q;
  logic [CNT_W-1:0]  cnt_write_q;
  logic [CNT_W-1:0]  cnt_rwim_q;
  logic [CNT_W-1:0]  cnt_drop_q;

  logic   is_empty;
  logic   is_full;
  logic   capture;
  logic   pop;
  logic   push;
  logic   drop;
  entry_t head;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    is_empty = (count == '0);
    is_full  = (count == FULL_CNT);
    capture  = (bus.cmd_in != CMD_NONE) && !bus.done;
    pop      = !is_empty && bus.out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push     = capture && (!is_full || pop);
    drop     = capture && is_full && !pop;
    // Storage is not reset, so the head is forced to zero while empty to keep outputs defined.
    head     = is_empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= '{cmd: bus.cmd_in, add: bus.add_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      cnt_read_q  <= '0;
      cnt_write_q <= '0;
      cnt_rwim_q  <= '0;
      cnt_drop_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (push && bus.cmd_in == CMD_READ) begin
        cnt_read_q <= sat_inc(cnt_read_q);
      end
      if (push && bus.cmd_in == CMD_WRITE) begin
        cnt_write_q <= sat_inc(cnt_write_q);
      end
      if (push && bus.cmd_in == CMD_RWIM) begin
        cnt_rwim_q <= sat_inc(cnt_rwim_q);
      end
      if (drop) begin
        cnt_drop_q <= sat_inc(cnt_drop_q);
      end
    end
  end

  assign bus.out_valid = !is_empty;
  assign bus.out_cmd   = head.cmd;
  assign bus.out_add   = head.add;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
  assign bus.cnt_read  = cnt_read_q;
  assign bus.cnt_write = cnt_write_q;
  assign bus.cnt_rwim  = cnt_rwim_q;
  assign bus.cnt_drop  = cnt_drop_q;
endmodule

// File: tb/tb_l_next_logger.sv
// Directed bench for l_next_logger: vector table for basic ordering/done/empty cases, hand sequences for the rest.
module tb_l_next_logger;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 26;
  localparam int CNT_W  = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  l_next_logger_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  l_next_logger #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] add;
    logic              dn;
    logic              rdy;
    logic              e_vld;
    logic [1:0]        e_cmd;
    logic [ADDR_W-1:0] e_add;
    logic              e_full;
    logic              e_empty;
    int                e_rd;
    int                e_wr;
    int                e_rw;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic rst, input logic [1:0] cmd, input logic [ADDR_W-1:0] add,
                         input logic dn, input logic rdy, input logic e_vld, input logic [1:0] e_cmd,
                         input logic [ADDR_W-1:0] e_add, input logic e_full, input logic e_empty,
                         input int e_rd, input int e_wr, input int e_rw);
    vec_t v;
    v.rst = rst; v.cmd = cmd; v.add = add; v.dn = dn; v.rdy = rdy;
    v.e_vld = e_vld; v.e_cmd = e_cmd; v.e_add = e_add; v.e_full = e_full; v.e_empty = e_empty;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_rw = e_rw;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] cmd, input logic [ADDR_W-1:0] add, input logic dn, input logic rdy);
    bus.cmd_in    = cmd;
    bus.add_in    = add;
    bus.done      = dn;
    bus.out_ready = rdy;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(2'd1, 26'h3, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    drive(2'd0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(2'd0, '0, 1'b0, 1'b0);

    //       rst cmd add          dn rdy  vld ecmd eadd         full empty rd wr rw
    add_vec(1, 1, 26'h0000005,   0, 0,   0, 0, 26'h0000000,   0, 1,    0, 0, 0);
    add_vec(1, 1, 26'h0000006,   0, 0,   0, 0, 26'h0000000,   0, 1,    0, 0, 0);
    add_vec(0, 1, 26'h0000010,   0, 0,   1, 1, 26'h0000010,   0, 0,    1, 0, 0);
    add_vec(0, 2, 26'h3FFFFFF,   0, 0,   1, 1, 26'h0000010,   0, 0,    1, 1, 0);
    add_vec(0, 3, 26'h1234567,   0, 0,   1, 1, 26'h0000010,   0, 0,    1, 1, 1);
    add_vec(0, 0, 26'h0000000,   0, 1,   1, 2, 26'h3FFFFFF,   0, 0,    1, 1, 1);
    add_vec(0, 0, 26'h0000000,   0, 1,   1, 3, 26'h1234567,   0, 0,    1, 1, 1);
    add_vec(0, 0, 26'h0000000,   0, 1,   0, 0, 26'h0000000,   0, 1,    1, 1, 1);
    add_vec(0, 0, 26'h0000000,   0, 1,   0, 0, 26'h0000000,   0, 1,    1, 1, 1);
    add_vec(0, 1, 26'h0000055,   0, 1,   1, 1, 26'h0000055,   0, 0,    2, 1, 1);
    add_vec(0, 0, 26'h0000000,   0, 0,   1, 1, 26'h0000055,   0, 0,    2, 1, 1);
    add_vec(0, 3, 26'h0000099,   1, 0,   1, 1, 26'h0000055,   0, 0,    2, 1, 1);
    add_vec(0, 0, 26'h0000000,   1, 1,   0, 0, 26'h0000000,   0, 1,    2, 1, 1);
    add_vec(0, 2, 26'h0000007,   0, 0,   1, 2, 26'h0000007,   0, 0,    2, 2, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      drive(tbl[i].cmd, tbl[i].add, tbl[i].dn, tbl[i].rdy);
      tick();
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_vld));
      check($sformatf("vec%0d_cmd", i),   32'(bus.out_cmd),   32'(tbl[i].e_cmd));
      check($sformatf("vec%0d_add", i),   32'(bus.out_add),   32'(tbl[i].e_add));
      check($sformatf("vec%0d_full", i),  32'(bus.full),      32'(tbl[i].e_full));
      check($sformatf("vec%0d_empty", i), 32'(bus.empty),     32'(tbl[i].e_empty));
      check($sformatf("vec%0d_rd", i),    32'(bus.cnt_read),  tbl[i].e_rd);
      check($sformatf("vec%0d_wr", i),    32'(bus.cnt_write), tbl[i].e_wr);
      check($sformatf("vec%0d_rw", i),    32'(bus.cnt_rwim),  tbl[i].e_rw);
      check($sformatf("vec%0d_drop", i),  32'(bus.cnt_drop),  0);
    end

    // Overflow: 10 READs into an undrained FIFO, then a push+pop while full.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(2'd1, 26'(i), 1'b0, 1'b0);
      tick();
      if (i == 6) check("ovf_not_full_7", 32'(bus.full), 0);
      if (i == 7) check("ovf_full_8", 32'(bus.full), 1);
    end
    check("ovf_cnt_read", 32'(bus.cnt_read), 8);
    check("ovf_cnt_drop", 32'(bus.cnt_drop), 2);
    check("ovf_head", 32'(bus.out_add), 0);
    drive(2'd1, 26'h100, 1'b0, 1'b1);
    tick();
    check("ovf_pp_drop", 32'(bus.cnt_drop), 2);
    check("ovf_pp_full", 32'(bus.full), 1);
    check("ovf_pp_read", 32'(bus.cnt_read), 9);
    drive(2'd0, '0, 1'b0, 1'b1);
    for (int j = 1; j < 8; j++) begin
      check($sformatf("ovf_drain%0d", j), 32'(bus.out_add), j);
      tick();
    end
    check("ovf_drain_last", 32'(bus.out_add), 32'h100);
    check("ovf_drain_last_vld", 32'(bus.out_valid), 1);
    tick();
    check("ovf_drained_empty", 32'(bus.empty), 1);

    // Wrap-around: sustained push+pop, each entry is the head one cycle later.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive((i % 2 == 0) ? 2'd2 : 2'd1, 26'(32'h200 + i), 1'b0, 1'b1);
      tick();
      check($sformatf("wrap%0d_vld", i), 32'(bus.out_valid), 1);
      check($sformatf("wrap%0d_cmd", i), 32'(bus.out_cmd), (i % 2 == 0) ? 2 : 1);
      check($sformatf("wrap%0d_add", i), 32'(bus.out_add), 32'h200 + i);
    end
    drive(2'd0, '0, 1'b0, 1'b1);
    tick();
    check("wrap_empty", 32'(bus.empty), 1);
    check("wrap_rd", 32'(bus.cnt_read), 10);
    check("wrap_wr", 32'(bus.cnt_write), 10);
    check("wrap_drop", 32'(bus.cnt_drop), 0);

    // done: RWIMs ignored while queued entries still drain.
    do_reset();
    drive(2'd1, 26'h11, 1'b0, 1'b0);
    tick();
    drive(2'd1, 26'h22, 1'b0, 1'b0);
    tick();
    drive(2'd3, 26'h33, 1'b1, 1'b1);
    tick();
    check("done_head2", 32'(bus.out_add), 32'h22);
    tick();
    check("done_empty", 32'(bus.empty), 1);
    tick();
    check("done_cnt_rwim", 32'(bus.cnt_rwim), 0);
    check("done_cnt_read", 32'(bus.cnt_read), 2);
    check("done_still_empty", 32'(bus.empty), 1);
    drive(2'd3, 26'h44, 1'b0, 1'b0);
    tick();
    check("done_resume_rwim", 32'(bus.cnt_rwim), 1);
    check("done_resume_head", 32'(bus.out_add), 32'h44);

    // Saturation with 4-bit counters, then reset with entries queued.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(2'd2, 26'(i), 1'b0, 1'b1);
      tick();
      if (i == 13) check("sat_wr_14", 32'(bus.cnt_write), 14);
      if (i == 14) check("sat_wr_15", 32'(bus.cnt_write), 15);
    end
    check("sat_wr_hold", 32'(bus.cnt_write), 15);
    check("sat_no_drop", 32'(bus.cnt_drop), 0);
    for (int i = 0; i < 3; i++) begin
      drive(2'd1, 26'(32'h300 + i), 1'b0, 1'b0);
      tick();
    end
    check("mid_not_empty", 32'(bus.empty), 0);
    reset = 1'b1;
    drive(2'd2, 26'h3AB, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    drive(2'd0, '0, 1'b0, 1'b0);
    check("mid_rst_empty", 32'(bus.empty), 1);
    check("mid_rst_vld", 32'(bus.out_valid), 0);
    check("mid_rst_add", 32'(bus.out_add), 0);
    check("mid_rst_rd", 32'(bus.cnt_read), 0);
    check("mid_rst_wr", 32'(bus.cnt_write), 0);
    check("mid_rst_rw", 32'(bus.cnt_rwim), 0);
    tick();
    check("mid_rst_stays_empty", 32'(bus.empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
